// File: rtl/siren_tone_meter_if.sv
// siren_tone_meter_if: audio line into the meter, measured half-period and status out of it
interface siren_tone_meter_if #(
    parameter int CNT_W = 16
);
    logic             audio_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             silent;
    logic [1:0]       trend;

    modport master (input audio_in, output period, period_valid, silent, trend);
    modport slave  (output audio_in, input period, period_valid, silent, trend);
endinterface

// File: rtl/siren_tone_meter.sv
// siren_tone_meter: half-period meter for a 1-bit square-wave line with silence and pitch-trend flags.
// Define TONE_DEGLITCH_EN to accept a level change only after DEGLITCH stable cycles.
module siren_tone_meter #(
    parameter int CNT_W    = 16,
    parameter int TIMEOUT  = 16'hFFFF,
    parameter int HYST     = 4,
    parameter int DEGLITCH = 3
) (
    input logic clk,
    input logic rst_n,
    siren_tone_meter_if.master bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   HYST_X  = (CNT_W + 1)'(HYST);

    typedef enum logic {IDLE, ARMED} state_t;

    state_t           state, state_next;
    logic             s1, s2, s3, level, edge_hit;
    logic             take, rearm, expire, first;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   new_ext, old_ext;

    // two-flop synchroniser for the asynchronous audio line
    always_ff @(posedge clk) begin
        if (!rst_n) {s1, s2} <= 2'b00;
        else        {s1, s2} <= {bus.audio_in, s1};
    end

`ifdef TONE_DEGLITCH_EN
    localparam int DG_W = $clog2(DEGLITCH + 1);
    logic [DG_W-1:0] stab;
    logic            filt;
    // a new level on s2 must hold DEGLITCH consecutive cycles before it replaces the filtered level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stab <= '0;
            filt <= 1'b0;
        end else if (s2 == filt) begin
            stab <= '0;
        end else if (stab == DG_W'(DEGLITCH - 1)) begin
            filt <= s2;
            stab <= '0;
        end else begin
            stab <= stab + 1'b1;
        end
    end
    assign level = filt;
`else
    assign level = s2;
`endif

    // previous accepted level; any difference is an edge of either polarity
    always_ff @(posedge clk) s3 <= !rst_n ? 1'b0 : level;
    assign edge_hit = level != s3;

    // state register
    always_ff @(posedge clk) state <= !rst_n ? IDLE : state_next;

    // next state: arm on any edge, disarm on timeout unless an edge arrives in the same cycle
    always_comb begin
        state_next = (state == IDLE) ? (edge_hit ? ARMED : IDLE) : (expire ? IDLE : ARMED);
    end

    // decode measurement, re-arm on a saturated count, and timeout
    always_comb begin
        take   = state == ARMED && edge_hit && cnt != CNT_MAX;
        rearm  = state == ARMED && edge_hit && cnt == CNT_MAX;
        expire = state == ARMED && !edge_hit && cnt == TO_LAST;
    end

    assign new_ext = {1'b0, cnt};
    assign old_ext = {1'b0, bus.period};

    // half-period counter, measurement register and status flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt              <= '0;
            first            <= 1'b1;
            bus.period       <= '0;
            bus.period_valid <= 1'b0;
            bus.silent       <= 1'b1;
            bus.trend        <= 2'b00;
        end else begin
            bus.period_valid <= take;
            if (edge_hit) cnt <= CNT_W'(1);
            else if (state == ARMED && cnt != CNT_MAX) cnt <= cnt + 1'b1;
            if (take) begin
                bus.period <= cnt;
                bus.silent <= 1'b0;
                first      <= 1'b0;
                bus.trend  <= first ? 2'b00 :
                              (new_ext + HYST_X < old_ext) ? 2'b01 :
                              (new_ext > old_ext + HYST_X) ? 2'b10 : 2'b00;
            end
            if (rearm) begin
                bus.silent <= 1'b1;
                first      <= 1'b1;
            end
            if (expire) begin
                bus.silent <= 1'b1;
                bus.trend  <= 2'b00;
                first      <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_siren_tone_meter.sv
// tb_siren_tone_meter: directed tone patterns; strobes checked against a scoreboard, plus timed state snapshots
`timescale 1ns/1ps
module tb_siren_tone_meter;
    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 300;
`ifdef TONE_DEGLITCH_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 3;
`endif

    typedef struct packed {
        logic [15:0] period;
        logic        valid;
        logic        silent;
        logic [1:0]  trend;
    } snap_t;

    logic  clk   = 1'b0;
    logic  rst_n = 1'b0;
    logic  done  = 1'b0;
    logic  pv_prev = 1'b0;
    int    passed = 0;
    int    total  = 0;
    snap_t sb_q[$];
    snap_t st_q[$];

    int         sw_p[9] = '{200, 190, 170, 200, 196, 192, 187, 191, 196};
    logic [1:0] sw_t[9] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2};

    siren_tone_meter_if #(.CNT_W(CNT_W)) bus ();

    siren_tone_meter #(
        .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .HYST(4), .DEGLITCH(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tog(input int n, input logic strobe, input int p, input logic [1:0] tr);
        idle(n);
        bus.audio_in = ~bus.audio_in;
        if (strobe) sb_q.push_back({16'(p), 1'b1, 1'b0, tr});
    endtask

    task automatic expect_state(input int p, input logic v, input logic s, input logic [1:0] tr);
        st_q.push_back({16'(p), v, s, tr});
    endtask

    // monitor: pops the scoreboard on every strobe and checks queued state snapshots
    always @(negedge clk) begin
        snap_t got;
        snap_t exp;
        got = {bus.period, bus.period_valid, bus.silent, bus.trend};
        if (bus.period_valid) begin
            total++;
            if (sb_q.size() == 0) begin
                $display("FAIL strobe: unexpected strobe period=%0d silent=%0b trend=%0d", got.period, got.silent, got.trend);
            end else begin
                exp = sb_q.pop_front();
                if (got == exp) passed++;
                else $display("FAIL strobe: got period=%0d silent=%0b trend=%0d, expected period=%0d silent=%0b trend=%0d",
                              got.period, got.silent, got.trend, exp.period, exp.silent, exp.trend);
            end
            total++;
            if (!pv_prev) passed++;
            else $display("FAIL back_to_back: period_valid high on consecutive cycles, expected a single-cycle strobe");
        end
        pv_prev = bus.period_valid;
        if (st_q.size() > 0) begin
            exp = st_q.pop_front();
            total++;
            if (got == exp) passed++;
            else $display("FAIL state @%0t: got period=%0d valid=%0b silent=%0b trend=%0d, expected period=%0d valid=%0b silent=%0b trend=%0d",
                          $time, got.period, got.valid, got.silent, got.trend, exp.period, exp.valid, exp.silent, exp.trend);
        end
        if (done) begin
            total++;
            if (sb_q.size() == 0) passed++;
            else $display("FAIL pending: %0d expected strobes never seen, expected 0", sb_q.size());
            $display("%0d/%0d checks passed", passed, total);
            $finish;
        end
    end

    initial begin
        bus.audio_in = 1'b0;
        rst_n = 1'b0;
        idle(3);
        expect_state(0, 0, 1, 0);
        rst_n = 1'b1;
        idle(100);
        expect_state(0, 0, 1, 0);
        // steady 100-cycle tone: first edge arms, exact strobe latency, then exact timeout cycle
        tog(1, 0, 0, 0);
        tog(100, 1, 100, 0);
        idle(LAT - 1);
        expect_state(0, 0, 1, 0);
        idle(1);
        expect_state(100, 1, 0, 0);
        tog(100 - LAT, 1, 100, 0);
        tog(100, 1, 100, 0);
        idle(LAT + TIMEOUT - 2);
        expect_state(100, 0, 0, 0);
        idle(1);
        expect_state(100, 0, 1, 0);
        // after timeout the next edge only arms, the following one measures
        idle(20);
        tog(1, 0, 0, 0);
        tog(100, 1, 100, 0);
        idle(TIMEOUT + 50);
        expect_state(100, 0, 1, 0);
        // sweep with hysteresis boundaries
        tog(1, 0, 0, 0);
        for (int i = 0; i < 9; i++) tog(sw_p[i], 1, sw_p[i], sw_t[i]);
        idle(TIMEOUT + 50);
        expect_state(196, 0, 1, 0);
        // edge coinciding with timeout wins; one cycle later the timeout wins
        tog(1, 0, 0, 0);
        tog(100, 1, 100, 0);
        tog(TIMEOUT - 1, 1, TIMEOUT - 1, 2);
        tog(TIMEOUT, 0, 0, 0);
        tog(50, 1, 50, 0);
        idle(TIMEOUT + 50);
        // reset mid-period discards the measurement and trend history
        tog(1, 0, 0, 0);
        tog(100, 1, 100, 0);
        tog(100, 1, 100, 0);
        idle(50);
        rst_n = 1'b0;
        idle(1);
        expect_state(0, 0, 1, 0);
        rst_n = 1'b1;
        idle(20);
        tog(1, 0, 0, 0);
        tog(150, 1, 150, 0);
        idle(TIMEOUT + 50);
        // 2-cycle glitch inside a 100-cycle half-period
        tog(1, 0, 0, 0);
        tog(100, 1, 100, 0);
`ifdef TONE_DEGLITCH_EN
        tog(40, 0, 0, 0);
        tog(2, 0, 0, 0);
        tog(58, 1, 100, 0);
`else
        tog(40, 1, 40, 1);
        tog(2, 1, 2, 1);
        tog(58, 1, 58, 2);
`endif
        idle(TIMEOUT + 50);
        done = 1'b1;
    end
endmodule
